// File: rtl/subt_seq_ctrl_pkg.sv
// Shared constants, FSM state encoding and slice-count helper for the
// sequential subtractor controller.
package subt_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/subt_seq_ctrl_if.sv
// Request/result bundle between a requester and the sequential subtractor.
interface subt_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a_i, b_i, bin_i,
        input  ready, busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a_i, b_i, bin_i,
        output ready, busy, done, diff, bout, zero
    );
endinterface

// File: rtl/subt_seq_ctrl_subt.sv
// Existing 4-bit subtractor slice: {bout, d} = a - b - bin.
module subt
    import subt_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);
    logic [SLICE_W:0] res_s;

    // One extra bit catches the borrow as the sign of the difference.
    assign res_s = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bin};
    assign d     = res_s[SLICE_W-1:0];
    assign bout  = res_s[SLICE_W];
endmodule

// File: rtl/subt_seq_ctrl.sv
// Runs a WIDTH-bit A - B - BIN through one shared 4-bit subtractor slice,
// LSB slice first, with the borrow registered between slices.
module subt_seq_ctrl
    import subt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic           clk,
    input  logic           rst,
    subt_seq_ctrl_if.slave bus
);
    localparam int                N        = slice_count(WIDTH);
    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               brw_q, brw_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [SLICE_W-1:0] sub_a_s;
    logic [SLICE_W-1:0] sub_b_s;
    logic [SLICE_W-1:0] sub_d_s;
    logic               sub_bout_s;
    logic               accept_s;

    assign sub_a_s = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign sub_b_s = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

    subt u_subt (
        .a    (sub_a_s),
        .b    (sub_b_s),
        .bin  (brw_q),
        .d    (sub_d_s),
        .bout (sub_bout_s)
    );

    // A start is taken only in IDLE or DONE; it is never queued while busy.
    assign accept_s = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state logic for the FSM, slice index and datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        if (accept_s) begin
            state_d = ST_RUN;
            idx_d   = {IDX_W{1'b0}};
            a_d     = bus.a_i;
            b_d     = bus.b_i;
            brw_d   = bus.bin_i;
            diff_d  = {WIDTH{1'b0}};
            bout_d  = 1'b0;
            zero_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    diff_d[int'(idx_q) * SLICE_W +: SLICE_W] = sub_d_s;
                    brw_d = sub_bout_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        idx_d   = {IDX_W{1'b0}};
                        bout_d  = sub_bout_s;
                        zero_d  = (diff_d == {WIDTH{1'b0}});
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d  = (state_d == ST_RUN);
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign bus.zero  = zero_q;

endmodule

// File: tb/tb_subt_seq_ctrl.sv
// Directed bench for subt_seq_ctrl: 16-bit vector table, handshake corner
// cases, asynchronous reset mid-operation and an exhaustive 4-bit sweep.
module tb_subt_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    subt_seq_ctrl_if #(.WIDTH(16)) if16 ();
    subt_seq_ctrl_if #(.WIDTH(4))  if4  ();

    subt_seq_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    subt_seq_ctrl #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on the 16-bit DUT; lat counts edges from the sampling edge to done.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output int lat);
        if16.start = 1'b1;
        if16.a_i   = a;
        if16.b_i   = b;
        if16.bin_i = bin;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if16.start = 1'b0;
                if16.a_i   = ~a;
                if16.b_i   = ~b;
                if16.bin_i = ~bin;
            end
        end while (!if16.done && lat < 20);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int lat);
        if4.start = 1'b1;
        if4.a_i   = a;
        if4.b_i   = b;
        if4.bin_i = bin;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if4.start = 1'b0;
                if4.a_i   = ~a;
                if4.b_i   = ~b;
            end
        end while (!if4.done && lat < 20);
    endtask

    initial begin
        int lat;
        int ndone;
        int t;
        int times[$];

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[4] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[9] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};

        if16.start = 1'b0; if16.a_i = 16'h0; if16.b_i = 16'h0; if16.bin_i = 1'b0;
        if4.start  = 1'b0; if4.a_i  = 4'h0;  if4.b_i  = 4'h0;  if4.bin_i  = 1'b0;

        #12;
        chk("rst_ready", {31'd0, if16.ready}, 32'd1);
        chk("rst_busy",  {31'd0, if16.busy},  32'd0);
        chk("rst_done",  {31'd0, if16.done},  32'd0);
        chk("rst_diff",  {16'd0, if16.diff},  32'd0);
        chk("rst_flags", {30'd0, if16.bout, if16.zero}, 32'd0);
        chk("rst4_out",  {25'd0, if4.ready, if4.busy, if4.done, if4.diff},
                         {25'd0, 1'b1, 1'b0, 1'b0, 4'h0});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table, back-to-back where a previous op leaves the DUT in DONE.
        for (int i = 0; i < 10; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("v%0d_lat", i),  lat, 32'd5);
            chk($sformatf("v%0d_diff", i), {16'd0, if16.diff}, {16'd0, vecs[i].diff});
            chk($sformatf("v%0d_bout", i), {31'd0, if16.bout}, {31'd0, vecs[i].bout});
            chk($sformatf("v%0d_zero", i), {31'd0, if16.zero}, {31'd0, vecs[i].zero});
            chk($sformatf("v%0d_rdy", i),  {30'd0, if16.ready, if16.busy}, 32'd2);
        end
        @(posedge clk);
        #1;
        chk("done_single", {31'd0, if16.done}, 32'd0);
        chk("zero_held",   {31'd0, if16.zero}, 32'd1);

        // A start pulse during RUN with other operands must be ignored.
        if16.start = 1'b1; if16.a_i = 16'h0005; if16.b_i = 16'h0003; if16.bin_i = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if16.start = 1'b0;
            end else if (lat == 2) begin
                chk("busy_run", {31'd0, if16.busy}, 32'd1);
                if16.start = 1'b1; if16.a_i = 16'hFFFF; if16.b_i = 16'h0000;
            end else begin
                if16.start = 1'b0;
            end
        end while (!if16.done && lat < 20);
        chk("ign_lat",  lat, 32'd5);
        chk("ign_diff", {16'd0, if16.diff}, 32'h0002);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (if16.done) ndone++;
        end
        chk("ign_no_extra_done", ndone, 32'd0);

        // start held high: one result every five cycles.
        if16.start = 1'b1; if16.a_i = 16'h0010; if16.b_i = 16'h0001; if16.bin_i = 1'b0;
        for (t = 1; t <= 16; t++) begin
            @(posedge clk);
            #1;
            if (if16.done) begin
                times.push_back(t);
                chk($sformatf("hold_diff_t%0d", t), {16'd0, if16.diff}, 32'h000F);
            end
        end
        if16.start = 1'b0;
        chk("hold_count", times.size(), 32'd3);
        if (times.size() == 3) begin
            chk("hold_t0", times[0], 32'd5);
            chk("hold_t1", times[1], 32'd10);
            chk("hold_t2", times[2], 32'd15);
        end
        repeat (8) @(posedge clk);
        #1;

        // Asynchronous reset after two slices of an op.
        if16.start = 1'b1; if16.a_i = 16'hFFFF; if16.b_i = 16'h0001; if16.bin_i = 1'b0;
        @(posedge clk); #1;
        if16.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_diff_nz", {31'd0, (if16.diff != 16'h0)}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, if16.ready}, 32'd1);
        chk("arst_busy",  {31'd0, if16.busy},  32'd0);
        chk("arst_diff",  {16'd0, if16.diff},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (if16.done) ndone++;
        end
        chk("arst_no_done", ndone, 32'd0);
        run16(16'h0005, 16'h0003, 1'b0, lat);
        chk("post_rst_lat",  lat, 32'd5);
        chk("post_rst_diff", {16'd0, if16.diff}, 32'h0002);

        // 4-bit instance: directed case then exhaustive sweep against a-b-bin.
        run4(4'h3, 4'h7, 1'b0, lat);
        chk("w4_lat",  lat, 32'd2);
        chk("w4_diff", {28'd0, if4.diff}, 32'hC);
        chk("w4_bout", {31'd0, if4.bout}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int ex;
                    int ex_d;
                    ex   = a - b - c;
                    ex_d = (ex < 0) ? ex + 16 : ex;
                    run4(a[3:0], b[3:0], c[0], lat);
                    chk($sformatf("sw_%0d_%0d_%0d_lat", a, b, c), lat, 32'd2);
                    chk($sformatf("sw_%0d_%0d_%0d_res", a, b, c),
                        {26'd0, if4.bout, if4.zero, if4.diff},
                        {26'd0, (ex < 0), (ex_d == 0), ex_d[3:0]});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
